// File: rtl/ldpc_msg_mem.sv
// LDPC message store: one write port, one registered read port, and a
// clear sweep that zeroes every word after reset or on request.
module ldpc_msg_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 8,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic             i_wen,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_ren,
    input  logic [AW-1:0]    i_raddr,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rval,
    output logic             o_busy,
    output logic             o_err
);
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             rval_q, rval_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             we;
    logic [IW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             wr_ok, rd_ok;

    // Not reset: the sweep that follows reset zeroes the contents.
    logic [WIDTH-1:0] mem [DEPTH];

    assign wr_ok = {1'b0, i_waddr} < DEPTH_W;
    assign rd_ok = {1'b0, i_raddr} < DEPTH_W;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rval_d  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        we      = 1'b0;
        wa      = i_waddr[IW-1:0];
        wd      = i_wdata;
        case (state_q)
            CLEAR: begin
                we    = 1'b1;
                wa    = cnt_q[IW-1:0];
                wd    = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = IDLE;
            end
            default: begin
                if (i_wen) begin
                    if (wr_ok) we = 1'b1;
                    else       err_d = 1'b1;
                end
                if (i_ren) begin
                    rval_d = 1'b1;
                    if (!rd_ok) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else if (BYPASS != 0 && i_wen && i_waddr == i_raddr) begin
                        rdata_d = i_wdata;
                    end else begin
                        rdata_d = mem[i_raddr[IW-1:0]];
                    end
                end
                // Clear still lets this cycle's accesses through; the sweep
                // then wipes whatever was written.
                if (i_clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            rval_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rval_q  <= rval_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign o_rdata = rdata_q;
    assign o_rval  = rval_q;
    assign o_busy  = (state_q == CLEAR);
    assign o_err   = err_q;
endmodule

// File: tb/tb_ldpc_msg_mem.sv
// Bench for ldpc_msg_mem: directed vector table, hand sequences for the
// clear/reset corners, then random traffic against a behavioural model.
module tb_ldpc_msg_mem;
    logic       clk = 1'b0;
    logic       xrst;
    logic       i_wen, i_ren, i_clr;
    logic [7:0] i_waddr, i_wdata, i_raddr;
    logic [7:0] o_rdata, rf_rdata;
    logic       o_rval, o_busy, o_err, rf_rval, rf_busy, rf_err;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    ldpc_msg_mem #(.WIDTH(8), .DEPTH(64), .AW(8), .BYPASS(1)) dut (
        .clk(clk), .xrst(xrst), .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_ren(i_ren), .i_raddr(i_raddr), .i_clr(i_clr),
        .o_rdata(o_rdata), .o_rval(o_rval), .o_busy(o_busy), .o_err(o_err));

    ldpc_msg_mem #(.WIDTH(8), .DEPTH(64), .AW(8), .BYPASS(0)) dut_rf (
        .clk(clk), .xrst(xrst), .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_ren(i_ren), .i_raddr(i_raddr), .i_clr(i_clr),
        .o_rdata(rf_rdata), .o_rval(rf_rval), .o_busy(rf_busy), .o_err(rf_err));

    typedef struct {
        logic       wen;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic       ren;
        logic [7:0] raddr;
        logic       clr;
        logic       e_rval;
        logic [7:0] e_rdata;
        logic       e_err;
        logic       e_busy;
    } vec_t;

    vec_t vt[15];

    // Behavioural model: remaining sweep cycles plus a plain word array.
    int         m_busy;
    logic [7:0] m_mem [64];
    logic       m_rval;
    logic [7:0] m_rdata;
    logic       m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wen, input logic [7:0] wa, input logic [7:0] wd,
                          input logic ren, input logic [7:0] ra, input logic clr);
        i_wen = wen; i_waddr = wa; i_wdata = wd;
        i_ren = ren; i_raddr = ra; i_clr = clr;
    endtask

    // Counts busy cycles starting from the current sample.
    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (o_busy === 1'b1 && n < 200) begin
            n++;
            tick();
            chk({nm, "_busy_rval"}, {31'd0, o_rval}, 32'd0);
        end
        chk({nm, "_busy_cycles"}, n, 64);
    endtask

    function automatic vec_t mk(logic wen, logic [7:0] wa, logic [7:0] wd, logic ren,
                                logic [7:0] ra, logic clr, logic rv, logic [7:0] rd,
                                logic er, logic bz);
        vec_t v;
        v.wen = wen; v.waddr = wa; v.wdata = wd; v.ren = ren; v.raddr = ra; v.clr = clr;
        v.e_rval = rv; v.e_rdata = rd; v.e_err = er; v.e_busy = bz;
        return v;
    endfunction

    function automatic void model_step(logic wen, logic [7:0] wa, logic [7:0] wd,
                                       logic ren, logic [7:0] ra, logic clr);
        if (m_busy > 0) begin
            m_busy--;
            m_rval = 1'b0;
        end else begin
            m_rval = ren;
            if (ren) begin
                if (ra >= 64) begin
                    m_rdata = 8'h00;
                    m_err   = 1'b1;
                end else if (wen && wa == ra) begin
                    m_rdata = wd;
                end else begin
                    m_rdata = m_mem[ra];
                end
            end
            if (wen) begin
                if (wa < 64) m_mem[wa] = wd;
                else         m_err = 1'b1;
            end
            if (clr) begin
                m_busy = 64;
                m_err  = 1'b0;
                foreach (m_mem[k]) m_mem[k] = 8'h00;
            end
        end
    endfunction

    initial begin
        xrst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (3) tick();
        chk("rst_busy",  {31'd0, o_busy}, 1);
        chk("rst_rval",  {31'd0, o_rval}, 0);
        chk("rst_rdata", {24'd0, o_rdata}, 0);
        chk("rst_err",   {31'd0, o_err}, 0);
        xrst = 1'b0;
        count_busy("init");

        // Directed table: each row is inputs for one cycle and outputs after it
        vt[0]  = mk(0, 0,  0,     1, 0,  0, 1, 8'h00, 0, 0);
        vt[1]  = mk(0, 0,  0,     1, 31, 0, 1, 8'h00, 0, 0);
        vt[2]  = mk(0, 0,  0,     1, 63, 0, 1, 8'h00, 0, 0);
        vt[3]  = mk(1, 5,  8'h7F, 0, 0,  0, 0, 8'h00, 0, 0);
        vt[4]  = mk(1, 6,  8'h80, 0, 0,  0, 0, 8'h00, 0, 0);
        vt[5]  = mk(0, 0,  0,     1, 5,  0, 1, 8'h7F, 0, 0);
        vt[6]  = mk(0, 0,  0,     1, 6,  0, 1, 8'h80, 0, 0);
        vt[7]  = mk(0, 0,  0,     0, 0,  0, 0, 8'h80, 0, 0);
        vt[8]  = mk(1, 9,  8'h11, 0, 0,  0, 0, 8'h80, 0, 0);
        vt[9]  = mk(1, 9,  8'h22, 1, 9,  0, 1, 8'h22, 0, 0);
        vt[10] = mk(0, 0,  0,     1, 9,  0, 1, 8'h22, 0, 0);
        vt[11] = mk(1, 70, 8'h55, 0, 0,  0, 0, 8'h22, 1, 0);
        vt[12] = mk(0, 0,  0,     1, 70, 0, 1, 8'h00, 1, 0);
        vt[13] = mk(0, 0,  0,     0, 0,  0, 0, 8'h00, 1, 0);
        vt[14] = mk(0, 0,  0,     0, 0,  1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 15; i++) begin
            set_in(vt[i].wen, vt[i].waddr, vt[i].wdata, vt[i].ren, vt[i].raddr, vt[i].clr);
            tick();
            chk($sformatf("vec%0d_rval", i),  {31'd0, o_rval},  {31'd0, vt[i].e_rval});
            chk($sformatf("vec%0d_rdata", i), {24'd0, o_rdata}, {24'd0, vt[i].e_rdata});
            chk($sformatf("vec%0d_err", i),   {31'd0, o_err},   {31'd0, vt[i].e_err});
            chk($sformatf("vec%0d_busy", i),  {31'd0, o_busy},  {31'd0, vt[i].e_busy});
            if (i == 9) chk("vec9_readfirst", {24'd0, rf_rdata}, 32'h11);
        end
        set_in(0, 0, 0, 0, 0, 0);
        count_busy("clr1");

        // Clear with a same-cycle write and read, then writes during the sweep
        set_in(1, 3, 8'hAA, 0, 0, 0);
        tick();
        set_in(1, 4, 8'h33, 1, 3, 1);
        tick();
        chk("clrw_rval",  {31'd0, o_rval}, 1);
        chk("clrw_rdata", {24'd0, o_rdata}, 32'hAA);
        set_in(1, 4, 8'h99, 1, 3, 1);
        count_busy("clr2");
        set_in(0, 0, 0, 1, 3, 0);
        tick();
        chk("swept3", {23'd0, o_rval, o_rdata}, 32'h100);
        set_in(0, 0, 0, 1, 4, 0);
        tick();
        chk("swept4", {23'd0, o_rval, o_rdata}, 32'h100);

        // Reset in the middle of a sweep restarts it from address 0
        set_in(1, 1, 8'h5A, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 1, 1);
        tick();
        chk("pre_rst_rdata", {24'd0, o_rdata}, 32'h5A);
        set_in(0, 0, 0, 0, 0, 0);
        repeat (20) tick();
        xrst = 1'b1;
        #1;
        chk("midrst_rdata", {24'd0, o_rdata}, 0);
        chk("midrst_busy",  {31'd0, o_busy}, 1);
        tick();
        xrst = 1'b0;
        count_busy("midrst");

        // Random traffic against the model, starting from the idle, zeroed state
        m_busy = 0; m_rval = 1'b0; m_rdata = 8'h00; m_err = 1'b0;
        foreach (m_mem[k]) m_mem[k] = 8'h00;
        for (int c = 0; c < 800; c++) begin
            logic       wen, ren, clr;
            logic [7:0] wa, wd, ra;
            wen = ($urandom_range(0, 1) == 1);
            ren = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 79) == 0);
            wa  = 8'($urandom_range(0, 71));
            ra  = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 71));
            wd  = 8'($urandom);
            set_in(wen, wa, wd, ren, ra, clr);
            tick();
            model_step(wen, wa, wd, ren, ra, clr);
            chk("rnd_rval",  {31'd0, o_rval},  {31'd0, m_rval});
            chk("rnd_rdata", {24'd0, o_rdata}, {24'd0, m_rdata});
            chk("rnd_err",   {31'd0, o_err},   {31'd0, m_err});
            chk("rnd_busy",  {31'd0, o_busy},  (m_busy > 0) ? 32'd1 : 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
